cpu_addr_gen: RTL and testbench
===============================

// Module: cpu_addr_gen
// PURPOSE
//  Parametrised addressing-mode sequencer for the 6502-class core. On a start pulse it fetches operand
//  bytes from the instruction stream and applies index registers and zero-page pointers. It then
//  returns the effective address (EA), the updated PC, and a page-cross flag.
//  The core's microcode drives it for every memory-operand opcode, so per-opcode address sequencing is
//  no longer hand-written in the core.
// PARAMETERS
//  DATA_W        8   data/register width; ADDR_W = 2*DATA_W (localparam), "page" = low DATA_W bits
//  PAGE_PENALTY  1   1: ABS,X / ABS,Y / (IND),Y take one extra cycle when the index add carries; 0: never
//  ZP_WRAP       1   1: ZP,X / ZP,Y / (IND,X) pointer arithmetic wraps inside page 0; 0: carry into high byte
// PORTS
//  clk         in   1       system clock, all state on rising edge
//  reset_n     in   1       asynchronous, active-low reset
//  start       in   1       request; sampled only when busy=0
//  mode        in   4       addressing mode, encodings in cpu_pkg (see BEHAVIOUR)
//  pc_in       in   ADDR_W  address of first operand byte (opcode address + 1)
//  x_in,y_in   in   DATA_W  index registers; captured on the accepted start edge
//  din         in   DATA_W  memory read data; valid the cycle after addr_out is presented
//  addr_out    out  ADDR_W  registered memory read address
//  busy        out  1       high from the accepted start until done
//  done        out  1       one-cycle pulse; ea, pc_next, page_cross, err valid while high and held after
//  ea          out  ADDR_W  effective address
//  pc_next     out  ADDR_W  pc_in + operand byte count (1 or 2)
//  page_cross  out  1       index add carried into the high byte
//  err         out  1       illegal mode code; pulses with done
// BEHAVIOUR
//  Reset: addr_out, ea, pc_next = 0; busy, done, page_cross, err = 0; state IDLE. Mid-operation reset
//   aborts immediately with no done pulse.
//  Modes: 0 IMM, 1 ZP, 2 ZPX, 3 ZPY, 4 ABS, 5 ABSX, 6 ABSY, 7 INDX, 8 INDY; 9-15 illegal.
//  States: IDLE, OP_LO, OP_HI, IDX, PTR_LO, PTR_HI, FIX.
//  Latency = rising edges from the accepted start edge (edge 1) to the edge that raises done:
//   IMM 1: ea=pc_in, no memory read.
//   ZP 2: ea={0,op}.
//   ZPX/ZPY 3: OP_LO, then IDX; ea={0,op+idx}.
//   ABS 3: OP_LO, OP_HI; ea={hi,lo}.
//   ABSX/ABSY 3, or 4 if carry and PAGE_PENALTY=1 (FIX adds the carry to hi). With PAGE_PENALTY=0
//    the carry is folded in at OP_HI.
//   INDX 5: OP_LO, IDX (ptr=op+X), PTR_LO reads ptr, PTR_HI reads ptr+1.
//   INDY 4, or 5 with penalty: OP_LO, PTR_LO reads op, PTR_HI reads op+1 and adds Y, optional FIX.
//  addr_out sequence: pc_in, then pc_in+1 for ABS*; or zero-page pointer bytes for IND*.
//   addr_out holds its last value when idle.
//  Arithmetic:
//   - All index adds are DATA_W-bit with carry-out.
//   - ZP_WRAP=1: ptr+1 and op+idx are mod 2^DATA_W within page 0. ZP_WRAP=0: the carry goes to bit DATA_W.
//   - page_cross = carry of the index add (ABSX/ABSY/INDY only; 0 for other modes).
//   - pc_next wraps mod 2^ADDR_W.
//  pc_next: +1 for IMM, ZP*, IND*; +2 for ABS*.
//  Illegal mode: done and err pulse at latency 1; ea=0, pc_next=pc_in.
//  start while busy=1 is ignored. start in the same cycle as done is ignored, because busy is still high.
//   The earliest next accept is the cycle after done.
//  x_in/y_in changes after the accept do not affect the result.
// STRUCTURE
//  cpu_pkg: mode encodings (AM_IMM..AM_INDY), state encodings, AM_LAST.
//  One sub-module, idx_adder: DATA_W-bit add with carry-in/out and a ZP_WRAP-controlled high-byte
//   propagate. Used for op+idx, ptr+1, and the FIX increment.
// TESTING
//  1 IMM, pc_in=0x0200, start -> done at edge 1; ea=0x0200, pc_next=0x0201, no read.
//  2 ZPX, op=0xF0, X=0x20, ZP_WRAP=1 -> ea=0x0010 at edge 3. With ZP_WRAP=0 -> ea=0x0110.
//  3 ABSX, bytes 0xFF,0x12, X=0x01 -> ea=0x1300, page_cross=1, done at edge 4.
//    Same stimulus with PAGE_PENALTY=0 -> done at edge 3.
//  4 INDX, op=0x40, X=0x05, mem[0x45]=0x34, mem[0x46]=0x12 -> addr_out 0x45 then 0x46;
//    ea=0x1234 at edge 5.
//  5 INDY, op=0xFF, mem[0xFF]=0x80, mem[0x00]=0x20 (wrap), Y=0x90 -> ea=0x2110, page_cross=1, edge 5.
//  6 Illegal mode=0xC -> done+err at edge 1. Then ABS start, start re-pulsed while busy (ignored),
//    reset_n low at edge 2 -> all outputs 0, no done.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared encodings for the addressing-mode sequencer: mode
//               codes, sequencer states and index-register selection helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int MODE_W = 4;

    // Addressing-mode encodings driven by the core microcode
    localparam logic [MODE_W-1:0] AM_IMM  = 4'd0;
    localparam logic [MODE_W-1:0] AM_ZP   = 4'd1;
    localparam logic [MODE_W-1:0] AM_ZPX  = 4'd2;
    localparam logic [MODE_W-1:0] AM_ZPY  = 4'd3;
    localparam logic [MODE_W-1:0] AM_ABS  = 4'd4;
    localparam logic [MODE_W-1:0] AM_ABSX = 4'd5;
    localparam logic [MODE_W-1:0] AM_ABSY = 4'd6;
    localparam logic [MODE_W-1:0] AM_INDX = 4'd7;
    localparam logic [MODE_W-1:0] AM_INDY = 4'd8;
    // Highest legal code; anything above is reported through err
    localparam logic [MODE_W-1:0] AM_LAST = AM_INDY;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_OP_LO  = 3'd1,
        ST_OP_HI  = 3'd2,
        ST_IDX    = 3'd3,
        ST_PTR_LO = 3'd4,
        ST_PTR_HI = 3'd5,
        ST_FIX    = 3'd6
    } state_t;

    // Modes that add the X register
    function automatic logic uses_x(input logic [MODE_W-1:0] m);
        return (m == AM_ZPX) || (m == AM_ABSX) || (m == AM_INDX);
    endfunction

    // Modes that add the Y register
    function automatic logic uses_y(input logic [MODE_W-1:0] m);
        return (m == AM_ZPY) || (m == AM_ABSY) || (m == AM_INDY);
    endfunction

endpackage
`default_nettype wire

// File: rtl/idx_adder.sv
`default_nettype none
// ============================================================================
// Module      : idx_adder
// Description : DATA_W-bit add with carry-in/carry-out. The carry-out either
//               propagates into the supplied high byte (WRAP=0) or is dropped
//               so the result stays inside the high byte's page (WRAP=1).
// Revision    : 1.0 - initial release
// ============================================================================
module idx_adder #(
    parameter int DATA_W = 8,
    parameter bit WRAP   = 1'b1
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                cin,
    input  logic [DATA_W-1:0]   hi_in,
    output logic [2*DATA_W-1:0] result,
    output logic                carry
);

    logic [DATA_W:0]   lo_full;
    logic [DATA_W-1:0] hi_out;

    // Low-byte add; the extra bit is the carry-out
    always_comb begin
        lo_full = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
    end

    generate
        if (WRAP) begin : g_wrap
            assign hi_out = hi_in;
        end else begin : g_carry
            assign hi_out = hi_in + {{(DATA_W-1){1'b0}}, lo_full[DATA_W]};
        end
    endgenerate

    assign carry  = lo_full[DATA_W];
    assign result = {hi_out, lo_full[DATA_W-1:0]};

endmodule
`default_nettype wire

// File: rtl/cpu_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : cpu_addr_gen
// Description : Addressing-mode sequencer. Fetches operand bytes, applies
//               index registers and zero-page pointers, and returns the
//               effective address, updated PC and page-cross flag.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_addr_gen
    import cpu_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter bit PAGE_PENALTY = 1'b1,
    parameter bit ZP_WRAP      = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [MODE_W-1:0]   mode,
    input  logic [2*DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0]   x_in,
    input  logic [DATA_W-1:0]   y_in,
    input  logic [DATA_W-1:0]   din,
    output logic [2*DATA_W-1:0] addr_out,
    output logic                busy,
    output logic                done,
    output logic [2*DATA_W-1:0] ea,
    output logic [2*DATA_W-1:0] pc_next,
    output logic                page_cross,
    output logic                err
);

    localparam int ADDR_W = 2 * DATA_W;
    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PC_TWO = ADDR_W'(2);

    state_t state, state_nxt;

    // Operation context captured at accept and while fetching
    logic [MODE_W-1:0] mode_r, mode_nxt;
    logic [DATA_W-1:0] idx_r, idx_nxt;    // selected index, 0 for unindexed modes
    logic [DATA_W-1:0] op_r, op_nxt;      // operand byte, later the pointer low byte
    logic [DATA_W-1:0] hi_r, hi_nxt;      // high byte waiting for the FIX increment
    logic [ADDR_W-1:0] ptr_r, ptr_nxt;    // zero-page pointer being read
    logic [ADDR_W-1:0] pc_r, pc_nxt;

    logic [ADDR_W-1:0] addr_nxt, ea_nxt, pcn_nxt;
    logic              busy_nxt, done_nxt, cross_nxt, err_nxt;

    // Zero-page adder: op+idx and ptr+1, page-wrapped when ZP_WRAP is set
    logic [DATA_W-1:0] zp_a, zp_b, zp_hi;
    logic              zp_cin;
    logic [ADDR_W-1:0] zp_result;
    logic              zp_carry;
    logic              unused_zp_carry;

    // Absolute adder: {hi,lo}+idx, carry always propagates into the high byte
    logic [DATA_W-1:0] abs_hi;
    logic [ADDR_W-1:0] abs_result;
    logic              abs_carry;

    idx_adder #(
        .DATA_W (DATA_W),
        .WRAP   (ZP_WRAP)
    ) u_zp_add (
        .a      (zp_a),
        .b      (zp_b),
        .cin    (zp_cin),
        .hi_in  (zp_hi),
        .result (zp_result),
        .carry  (zp_carry)
    );

    idx_adder #(
        .DATA_W (DATA_W),
        .WRAP   (1'b0)
    ) u_abs_add (
        .a      (op_r),
        .b      (idx_r),
        .cin    (1'b0),
        .hi_in  (abs_hi),
        .result (abs_result),
        .carry  (abs_carry)
    );

    // Zero-page page wrap is already reflected in zp_result
    assign unused_zp_carry = zp_carry;

    // The deferred increment in FIX reuses the high byte captured one cycle earlier
    assign abs_hi = (state == ST_FIX) ? hi_r : din;

    // Zero-page adder operands: pointer increment in PTR_LO, op+idx otherwise
    always_comb begin
        zp_a   = op_r;
        zp_b   = idx_r;
        zp_cin = 1'b0;
        zp_hi  = '0;
        if (state == ST_PTR_LO) begin
            zp_a   = ptr_r[DATA_W-1:0];
            zp_b   = '0;
            zp_cin = 1'b1;
            zp_hi  = ptr_r[ADDR_W-1:DATA_W];
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        mode_nxt  = mode_r;
        idx_nxt   = idx_r;
        op_nxt    = op_r;
        hi_nxt    = hi_r;
        ptr_nxt   = ptr_r;
        pc_nxt    = pc_r;
        addr_nxt  = addr_out;
        busy_nxt  = busy & ~done;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        ea_nxt    = ea;
        pcn_nxt   = pc_next;
        cross_nxt = page_cross;

        case (state)
            ST_IDLE: begin
                if (start && !busy) begin
                    mode_nxt = mode;
                    pc_nxt   = pc_in;
                    idx_nxt  = uses_x(mode) ? x_in : (uses_y(mode) ? y_in : '0);
                    busy_nxt = 1'b1;
                    if (mode == AM_IMM) begin
                        done_nxt  = 1'b1;
                        ea_nxt    = pc_in;
                        pcn_nxt   = pc_in + PC_ONE;
                        cross_nxt = 1'b0;
                    end else if (mode > AM_LAST) begin
                        done_nxt  = 1'b1;
                        err_nxt   = 1'b1;
                        ea_nxt    = '0;
                        pcn_nxt   = pc_in;
                        cross_nxt = 1'b0;
                    end else begin
                        state_nxt = ST_OP_LO;
                        addr_nxt  = pc_in;
                    end
                end
            end

            ST_OP_LO: begin
                op_nxt = din;
                case (mode_r)
                    AM_ZP: begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                        ea_nxt    = {{DATA_W{1'b0}}, din};
                        pcn_nxt   = pc_r + PC_ONE;
                        cross_nxt = 1'b0;
                    end
                    AM_ZPX, AM_ZPY, AM_INDX: begin
                        state_nxt = ST_IDX;
                    end
                    AM_ABS, AM_ABSX, AM_ABSY: begin
                        state_nxt = ST_OP_HI;
                        addr_nxt  = pc_r + PC_ONE;
                    end
                    AM_INDY: begin
                        state_nxt = ST_PTR_LO;
                        ptr_nxt   = {{DATA_W{1'b0}}, din};
                        addr_nxt  = {{DATA_W{1'b0}}, din};
                    end
                    default: begin
                        state_nxt = ST_IDLE;
                        busy_nxt  = 1'b0;
                    end
                endcase
            end

            ST_IDX: begin
                if (mode_r == AM_INDX) begin
                    state_nxt = ST_PTR_LO;
                    ptr_nxt   = zp_result;
                    addr_nxt  = zp_result;
                end else begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                    ea_nxt    = zp_result;
                    pcn_nxt   = pc_r + PC_ONE;
                    cross_nxt = 1'b0;
                end
            end

            ST_PTR_LO: begin
                op_nxt    = din;
                ptr_nxt   = zp_result;
                addr_nxt  = zp_result;
                state_nxt = ST_PTR_HI;
            end

            ST_OP_HI, ST_PTR_HI: begin
                hi_nxt = din;
                if (mode_r == AM_INDX) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                    ea_nxt    = {din, op_r};
                    pcn_nxt   = pc_r + PC_ONE;
                    cross_nxt = 1'b0;
                end else if (PAGE_PENALTY && abs_carry) begin
                    state_nxt = ST_FIX;
                end else begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                    ea_nxt    = abs_result;
                    pcn_nxt   = (mode_r == AM_INDY) ? pc_r + PC_ONE : pc_r + PC_TWO;
                    cross_nxt = abs_carry;
                end
            end

            ST_FIX: begin
                state_nxt = ST_IDLE;
                done_nxt  = 1'b1;
                ea_nxt    = abs_result;
                pcn_nxt   = (mode_r == AM_INDY) ? pc_r + PC_ONE : pc_r + PC_TWO;
                cross_nxt = abs_carry;
            end

            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_r     <= '0;
            idx_r      <= '0;
            op_r       <= '0;
            hi_r       <= '0;
            ptr_r      <= '0;
            pc_r       <= '0;
            addr_out   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ea         <= '0;
            pc_next    <= '0;
            page_cross <= 1'b0;
            err        <= 1'b0;
        end else begin
            mode_r     <= mode_nxt;
            idx_r      <= idx_nxt;
            op_r       <= op_nxt;
            hi_r       <= hi_nxt;
            ptr_r      <= ptr_nxt;
            pc_r       <= pc_nxt;
            addr_out   <= addr_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            ea         <= ea_nxt;
            pc_next    <= pcn_nxt;
            page_cross <= cross_nxt;
            err        <= err_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_addr_gen
// Description : Self-checking bench for cpu_addr_gen. Four instances cover
//               every PAGE_PENALTY / ZP_WRAP combination against a shared
//               memory and an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_addr_gen;
    import cpu_pkg::*;

    localparam int N = 4;   // instance i: PAGE_PENALTY = i%2, ZP_WRAP = i/2

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  mode;
    logic [15:0] pc_in;
    logic [7:0]  x_in, y_in;

    logic [N-1:0][15:0] addr_o, ea_o, pcn_o;
    logic [N-1:0][7:0]  din;
    logic [N-1:0]       busy_o, done_o, cross_o, err_o;

    logic [7:0] mem [0:65535];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_dut
            cpu_addr_gen #(
                .DATA_W       (8),
                .PAGE_PENALTY (bit'(g % 2)),
                .ZP_WRAP      (bit'(g / 2))
            ) u_dut (
                .clk        (clk),
                .reset_n    (reset_n),
                .start      (start),
                .mode       (mode),
                .pc_in      (pc_in),
                .x_in       (x_in),
                .y_in       (y_in),
                .din        (din[g]),
                .addr_out   (addr_o[g]),
                .busy       (busy_o[g]),
                .done       (done_o[g]),
                .ea         (ea_o[g]),
                .pc_next    (pcn_o[g]),
                .page_cross (cross_o[g]),
                .err        (err_o[g])
            );
            assign din[g] = mem[addr_o[g]];
        end
    endgenerate

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model results per instance
    int e_ea [N];
    int e_pcn[N];
    int e_pcr[N];
    int e_err[N];
    int e_lat[N];
    int e_nr [N];
    int e_rd [N][3];

    // Observed results per instance
    int r_ea [N];
    int r_pcn[N];
    int r_pcr[N];
    int r_err[N];
    int r_lat[N];

    task automatic model(input int i, input logic [3:0] m, input logic [15:0] pc,
                         input logic [7:0] x, input logic [7:0] y);
        bit pw  = (i % 2) == 1;
        bit zw  = (i / 2) == 1;
        int op  = int'(mem[pc]);
        int op2 = int'(mem[(int'(pc) + 1) % 65536]);
        int idx, p, p1, base, lo, cr;
        idx = (m == 2 || m == 5 || m == 7) ? int'(x) : ((m == 3 || m == 6 || m == 8) ? int'(y) : 0);
        e_err[i] = 0;
        e_pcr[i] = 0;
        e_nr[i]  = 0;
        e_pcn[i] = (int'(pc) + 1) % 65536;
        case (m)
            0: begin e_ea[i] = int'(pc); e_lat[i] = 1; end
            1: begin
                e_ea[i] = op; e_lat[i] = 2;
                e_nr[i] = 1; e_rd[i][0] = int'(pc);
            end
            2, 3: begin
                p = op + idx;
                e_ea[i] = zw ? p % 256 : p; e_lat[i] = 3;
                e_nr[i] = 1; e_rd[i][0] = int'(pc);
            end
            4, 5, 6: begin
                base = op2 * 256 + op;
                cr = (op + idx > 255) ? 1 : 0;
                e_ea[i]  = (base + idx) % 65536;
                e_pcr[i] = cr;
                e_lat[i] = 3 + ((pw && cr == 1) ? 1 : 0);
                e_pcn[i] = (int'(pc) + 2) % 65536;
                e_nr[i] = 2; e_rd[i][0] = int'(pc); e_rd[i][1] = (int'(pc) + 1) % 65536;
            end
            7: begin
                p  = op + idx;
                if (zw) p = p % 256;
                p1 = zw ? (p + 1) % 256 : p + 1;
                e_ea[i] = int'(mem[p1]) * 256 + int'(mem[p]); e_lat[i] = 5;
                e_nr[i] = 3; e_rd[i][0] = int'(pc); e_rd[i][1] = p; e_rd[i][2] = p1;
            end
            8: begin
                p  = op;
                p1 = zw ? (op + 1) % 256 : op + 1;
                lo = int'(mem[p]);
                base = int'(mem[p1]) * 256 + lo;
                cr = (lo + idx > 255) ? 1 : 0;
                e_ea[i]  = (base + idx) % 65536;
                e_pcr[i] = cr;
                e_lat[i] = 4 + ((pw && cr == 1) ? 1 : 0);
                e_nr[i] = 3; e_rd[i][0] = int'(pc); e_rd[i][1] = p; e_rd[i][2] = p1;
            end
            default: begin
                e_ea[i] = 0; e_pcn[i] = int'(pc); e_err[i] = 1; e_lat[i] = 1;
            end
        endcase
    endtask

    // One operation on all instances; optionally keeps start asserted while busy
    task automatic run_txn(input logic [3:0] m, input logic [15:0] pc,
                           input logic [7:0] x, input logic [7:0] y, input bit nuis);
        int maxlat = 0;
        int minlat = 100;
        int start_last;
        int dcount[N];
        int nseen[N];
        logic [15:0] seen[N][8];
        logic [15:0] pre_addr[N];
        for (int i = 0; i < N; i++) begin
            model(i, m, pc, x, y);
            if (e_lat[i] > maxlat) maxlat = e_lat[i];
            if (e_lat[i] < minlat) minlat = e_lat[i];
            dcount[i]   = 0;
            nseen[i]    = 0;
            r_lat[i]    = 0;
            pre_addr[i] = addr_o[i];
        end
        start_last = nuis ? minlat + 1 : 1;
        @(negedge clk);
        start = 1'b1; mode = m; pc_in = pc; x_in = x; y_in = y;
        for (int e = 1; e <= maxlat + 2; e++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (done_o[i]) begin
                    dcount[i]++;
                    r_lat[i] = e;
                    r_ea[i]  = int'(ea_o[i]);
                    r_pcn[i] = int'(pcn_o[i]);
                    r_pcr[i] = int'(cross_o[i]);
                    r_err[i] = int'(err_o[i]);
                end
                if (e < e_lat[i] && nseen[i] < 8) begin
                    if (nseen[i] == 0 || seen[i][nseen[i]-1] != addr_o[i]) begin
                        seen[i][nseen[i]] = addr_o[i];
                        nseen[i]++;
                    end
                end
            end
            start = (e + 1 <= start_last);
            x_in  = 8'($urandom);
            y_in  = 8'($urandom);
        end
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            check($sformatf("i%0d m%0d done_count", i, m), dcount[i], 1);
            check($sformatf("i%0d m%0d latency", i, m), r_lat[i], e_lat[i]);
            check($sformatf("i%0d m%0d ea", i, m), r_ea[i], e_ea[i]);
            check($sformatf("i%0d m%0d pc_next", i, m), r_pcn[i], e_pcn[i]);
            check($sformatf("i%0d m%0d page_cross", i, m), r_pcr[i], e_pcr[i]);
            check($sformatf("i%0d m%0d err", i, m), r_err[i], e_err[i]);
            check($sformatf("i%0d m%0d busy_end", i, m), busy_o[i], 0);
            check($sformatf("i%0d m%0d read_count", i, m), nseen[i], e_nr[i]);
            for (int k = 0; k < e_nr[i] && k < nseen[i]; k++)
                check($sformatf("i%0d m%0d read%0d", i, m, k), seen[i][k], e_rd[i][k]);
            if (e_nr[i] == 0)
                check($sformatf("i%0d m%0d addr_hold", i, m), addr_o[i], pre_addr[i]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s i%0d addr/ea", tag, i), {addr_o[i], ea_o[i]}, 32'h0);
            check($sformatf("%s i%0d pcn/flags", tag, i),
                  {12'h0, pcn_o[i], busy_o[i], done_o[i], cross_o[i], err_o[i]}, 32'h0);
        end
    endtask

    initial begin
        int nd;
        logic [3:0]  m;
        logic [15:0] pc;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        reset_n = 1'b0; start = 1'b0; mode = '0; pc_in = '0; x_in = '0; y_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // IMM
        run_txn(AM_IMM, 16'h0200, 8'h00, 8'h00, 1'b1);
        check("t1 ea", r_ea[3], 32'h0200);
        check("t1 pc_next", r_pcn[3], 32'h0201);
        check("t1 latency", r_lat[3], 1);

        // ZPX with and without zero-page wrap
        mem[16'h0300] = 8'hF0;
        run_txn(AM_ZPX, 16'h0300, 8'h20, 8'h00, 1'b0);
        check("t2 ea wrap", r_ea[3], 32'h0010);
        check("t2 ea nowrap", r_ea[0], 32'h0110);
        check("t2 latency", r_lat[3], 3);

        // ABSX crossing a page, with and without penalty
        mem[16'h0300] = 8'hFF; mem[16'h0301] = 8'h12;
        run_txn(AM_ABSX, 16'h0300, 8'h01, 8'h00, 1'b0);
        check("t3 ea", r_ea[3], 32'h1300);
        check("t3 page_cross", r_pcr[3], 1);
        check("t3 latency penalty", r_lat[3], 4);
        check("t3 latency nopenalty", r_lat[2], 3);

        // INDX
        mem[16'h0300] = 8'h40; mem[16'h0045] = 8'h34; mem[16'h0046] = 8'h12;
        run_txn(AM_INDX, 16'h0300, 8'h05, 8'h00, 1'b1);
        check("t4 ea", r_ea[3], 32'h1234);
        check("t4 latency", r_lat[3], 5);

        // INDY with pointer wrap
        mem[16'h0300] = 8'hFF; mem[16'h00FF] = 8'h80; mem[16'h0000] = 8'h20;
        run_txn(AM_INDY, 16'h0300, 8'h00, 8'h90, 1'b0);
        check("t5 ea", r_ea[3], 32'h2110);
        check("t5 page_cross", r_pcr[3], 1);
        check("t5 latency", r_lat[3], 5);

        // Illegal mode
        run_txn(4'hC, 16'h0400, 8'h00, 8'h00, 1'b1);
        check("t6 err", r_err[3], 1);
        check("t6 latency", r_lat[3], 1);
        check("t6 pc_next", r_pcn[3], 32'h0400);

        // ABS aborted by reset while start is re-pulsed
        @(negedge clk);
        start = 1'b1; mode = AM_ABS; pc_in = 16'h0500;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) check($sformatf("t6 busy i%0d", i), busy_o[i], 1);
        @(negedge clk);
        start = 1'b1;
        #2 reset_n = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_all_zero("midreset");
        nd = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            nd += int'($countones(done_o));
        end
        check("t6 no done after abort", nd, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized operations
        for (int t = 0; t < 160; t++) begin
            m  = 4'($urandom_range(0, 9));
            if (m == 4'd9) m = 4'($urandom_range(9, 15));
            pc = 16'($urandom_range(16'h0300, 16'hFFFF));
            run_txn(m, pc, 8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
